// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: forwards gray pixels to a 3-line buffer, generates 3x3 window reads and emits Sobel edge pixels.
// Optional build macro SOBEL_THRESHOLD_EN binarises edge_value against THRESHOLD.
module sobel_window_ctrl #(
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned ADDRESSWIDTH = 19,
    parameter int unsigned BITWIDTH     = 8,
    parameter int unsigned THRESHOLD    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    gray_valid,
    input  logic [ADDRESSWIDTH-1:0] gray_address,
    input  logic [BITWIDTH-1:0]     gray_in,
    output logic                    we,
    output logic [ADDRESSWIDTH-1:0] input_rgb_address,
    output logic [BITWIDTH-1:0]     gray_input,
    output logic [ADDRESSWIDTH-1:0] address_center,
    output logic [ADDRESSWIDTH-1:0] address_left_up,
    output logic [ADDRESSWIDTH-1:0] address_left,
    output logic [ADDRESSWIDTH-1:0] address_left_down,
    output logic [ADDRESSWIDTH-1:0] address_up,
    output logic [ADDRESSWIDTH-1:0] address_down,
    output logic [ADDRESSWIDTH-1:0] address_right_up,
    output logic [ADDRESSWIDTH-1:0] address_right,
    output logic [ADDRESSWIDTH-1:0] address_righ_down,
    input  logic [BITWIDTH-1:0]     gray_center,
    input  logic [BITWIDTH-1:0]     gray_left_up,
    input  logic [BITWIDTH-1:0]     gray_left,
    input  logic [BITWIDTH-1:0]     gray_left_down,
    input  logic [BITWIDTH-1:0]     gray_up,
    input  logic [BITWIDTH-1:0]     gray_down,
    input  logic [BITWIDTH-1:0]     gray_right_up,
    input  logic [BITWIDTH-1:0]     gray_right,
    input  logic [BITWIDTH-1:0]     gray_right_down,
    output logic                    edge_valid,
    output logic [ADDRESSWIDTH-1:0] edge_address,
    output logic [BITWIDTH-1:0]     edge_value,
    output logic                    frame_done
);

    localparam int unsigned FRAME_PIX = H_RES * V_RES;
    localparam logic [ADDRESSWIDTH-1:0] ZERO_A     = {ADDRESSWIDTH{1'b0}};
    localparam logic [ADDRESSWIDTH-1:0] ONE_A      = {{(ADDRESSWIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESSWIDTH-1:0] HRES_A     = ADDRESSWIDTH'(H_RES);
    localparam logic [ADDRESSWIDTH-1:0] LEAD_A     = ADDRESSWIDTH'(H_RES + 1);
    localparam logic [ADDRESSWIDTH-1:0] LAST_A     = ADDRESSWIDTH'(FRAME_PIX - 1);
    localparam logic [ADDRESSWIDTH-1:0] FLUSH_A    = ADDRESSWIDTH'(FRAME_PIX - H_RES - 1);
    localparam logic [ADDRESSWIDTH-1:0] LAST_ROW_A = ADDRESSWIDTH'(FRAME_PIX - H_RES);
    localparam logic [ADDRESSWIDTH-1:0] LAST_COL_A = ADDRESSWIDTH'(H_RES - 1);
    localparam logic [BITWIDTH-1:0]     ZERO_D     = {BITWIDTH{1'b0}};
    localparam logic [BITWIDTH-1:0]     FULL_D     = {BITWIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_r;
    logic [ADDRESSWIDTH-1:0] flush_ptr_r;

    logic                    run_slot_s;
    logic                    flush_slot_s;
    logic                    slot_s;
    logic                    border_s;
    logic [ADDRESSWIDTH-1:0] slot_p_s;
    logic [ADDRESSWIDTH-1:0] col_s;
    logic [ADDRESSWIDTH-1:0] win_c_s, win_lu_s, win_l_s, win_ld_s, win_u_s;
    logic [ADDRESSWIDTH-1:0] win_d_s, win_ru_s, win_r_s, win_rd_s;

    logic                    v0_r, v1_r, v2_r, v3_r;
    logic                    b0_r, b1_r, b2_r, b3_r;
    logic [ADDRESSWIDTH-1:0] p0_r, p1_r, p2_r, p3_r;
    logic signed [10:0]      gx_s, gy_s, gx_r, gy_r;
    logic [11:0]             mag_s;
    logic [BITWIDTH-1:0]     shaped_s;
    logic                    unused_s;

    function automatic logic signed [10:0] widen(input logic [BITWIDTH-1:0] v);
        return $signed(11'(v));
    endfunction

    function automatic logic [10:0] mag11(input logic signed [10:0] v);
        return v[10] ? 11'(-v) : 11'(v);
    endfunction

    // Slot arbitration: a live pixel's slot beats the flush pointer; the pointer then holds.
    always_comb begin
        run_slot_s   = gray_valid && ((state_r == RUN) || (state_r == FLUSH)) && (gray_address >= LEAD_A);
        flush_slot_s = (state_r == FLUSH) && !run_slot_s;
        slot_s       = run_slot_s || flush_slot_s;
        if (run_slot_s) begin
            slot_p_s = gray_address - LEAD_A;
        end else begin
            slot_p_s = flush_ptr_r;
        end
        col_s    = slot_p_s % HRES_A;
        border_s = (slot_p_s < HRES_A) || (slot_p_s >= LAST_ROW_A) ||
                   (col_s == ZERO_A) || (col_s == LAST_COL_A);
    end

    // Window addresses; border pixels collapse every tap onto the centre.
    always_comb begin
        if (border_s) begin
            win_c_s  = slot_p_s;
            win_lu_s = slot_p_s;
            win_l_s  = slot_p_s;
            win_ld_s = slot_p_s;
            win_u_s  = slot_p_s;
            win_d_s  = slot_p_s;
            win_ru_s = slot_p_s;
            win_r_s  = slot_p_s;
            win_rd_s = slot_p_s;
        end else begin
            win_c_s  = slot_p_s;
            win_u_s  = slot_p_s - HRES_A;
            win_d_s  = slot_p_s + HRES_A;
            win_l_s  = slot_p_s - ONE_A;
            win_r_s  = slot_p_s + ONE_A;
            win_lu_s = slot_p_s - HRES_A - ONE_A;
            win_ru_s = slot_p_s - HRES_A + ONE_A;
            win_ld_s = slot_p_s + HRES_A - ONE_A;
            win_rd_s = slot_p_s + HRES_A + ONE_A;
        end
    end

    // Frame accounting FSM and flush pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            flush_ptr_r <= ZERO_A;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gray_valid && (gray_address == ZERO_A)) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (gray_valid && (gray_address == LAST_A)) begin
                        state_r     <= FLUSH;
                        flush_ptr_r <= FLUSH_A;
                    end
                end
                FLUSH: begin
                    if (gray_valid && (gray_address == LAST_A)) begin
                        flush_ptr_r <= FLUSH_A;
                    end else if (flush_slot_s) begin
                        if (flush_ptr_r == LAST_A) begin
                            state_r <= RUN;
                        end else begin
                            flush_ptr_r <= flush_ptr_r + ONE_A;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    flush_ptr_r <= ZERO_A;
                end
            endcase
        end
    end

    // Buffer write port and window address registers (E0).
    always_ff @(posedge clk) begin
        if (rst) begin
            we                <= 1'b0;
            input_rgb_address <= ZERO_A;
            gray_input        <= ZERO_D;
            address_center    <= ZERO_A;
            address_left_up   <= ZERO_A;
            address_left      <= ZERO_A;
            address_left_down <= ZERO_A;
            address_up        <= ZERO_A;
            address_down      <= ZERO_A;
            address_right_up  <= ZERO_A;
            address_right     <= ZERO_A;
            address_righ_down <= ZERO_A;
            v0_r              <= 1'b0;
            b0_r              <= 1'b0;
            p0_r              <= ZERO_A;
        end else begin
            we                <= gray_valid;
            input_rgb_address <= gray_valid ? gray_address : ZERO_A;
            gray_input        <= gray_valid ? gray_in : ZERO_D;
            address_center    <= win_c_s;
            address_left_up   <= win_lu_s;
            address_left      <= win_l_s;
            address_left_down <= win_ld_s;
            address_up        <= win_u_s;
            address_down      <= win_d_s;
            address_right_up  <= win_ru_s;
            address_right     <= win_r_s;
            address_righ_down <= win_rd_s;
            v0_r              <= slot_s;
            b0_r              <= border_s;
            p0_r              <= slot_p_s;
        end
    end

    // Delay line covering the buffer's two-cycle read latency (E1, E2).
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            b1_r <= 1'b0;
            b2_r <= 1'b0;
            p1_r <= ZERO_A;
            p2_r <= ZERO_A;
        end else begin
            v1_r <= v0_r;
            v2_r <= v1_r;
            b1_r <= b0_r;
            b2_r <= b1_r;
            p1_r <= p0_r;
            p2_r <= p1_r;
        end
    end

    // Horizontal and vertical Sobel kernels.
    always_comb begin
        gx_s = (widen(gray_right_up) + (widen(gray_right) <<< 1) + widen(gray_right_down)) -
               (widen(gray_left_up)  + (widen(gray_left)  <<< 1) + widen(gray_left_down));
        gy_s = (widen(gray_left_down) + (widen(gray_down) <<< 1) + widen(gray_right_down)) -
               (widen(gray_left_up)   + (widen(gray_up)   <<< 1) + widen(gray_right_up));
    end

    // Gradient registers (E3).
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r <= 1'b0;
            b3_r <= 1'b0;
            p3_r <= ZERO_A;
            gx_r <= 11'sd0;
            gy_r <= 11'sd0;
        end else begin
            v3_r <= v2_r;
            b3_r <= b2_r;
            p3_r <= p2_r;
            gx_r <= gx_s;
            gy_r <= gy_s;
        end
    end

    // L1 magnitude shaped to the output sample range.
    always_comb begin
        mag_s = {1'b0, mag11(gx_r)} + {1'b0, mag11(gy_r)};
`ifdef SOBEL_THRESHOLD_EN
        if (mag_s >= 12'(THRESHOLD)) begin
            shaped_s = FULL_D;
        end else begin
            shaped_s = ZERO_D;
        end
`else
        if (mag_s > 12'(FULL_D)) begin
            shaped_s = FULL_D;
        end else begin
            shaped_s = mag_s[BITWIDTH-1:0];
        end
`endif
    end

`ifdef SOBEL_THRESHOLD_EN
    assign unused_s = ^{gray_center, gray_input[0]};
`else
    assign unused_s = ^{gray_center, 32'(THRESHOLD)};
`endif

    // Edge output registers (E4).
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_valid   <= 1'b0;
            edge_address <= ZERO_A;
            edge_value   <= ZERO_D;
            frame_done   <= 1'b0;
        end else begin
            edge_valid   <= v3_r;
            edge_address <= v3_r ? p3_r : ZERO_A;
            edge_value   <= (v3_r && !b3_r) ? shaped_s : ZERO_D;
            frame_done   <= v3_r && (p3_r == LAST_A);
        end
    end

endmodule
